// File: rtl/posit_accum_stream_if.sv
// Element stream into, and burst result out of, the posit accumulator.
// The slave modport is the accumulator's view; master is the driver/consumer side.
interface posit_accum_stream_if #(
    parameter int FRAC_W  = 28,
    parameter int SCALE_W = 8,
    parameter int ACC_W   = 128,
    parameter int CNT_W   = 16
);
    logic                      in_valid;
    logic                      in_ready;
    logic                      in_sign;
    logic                      in_zero;
    logic                      in_inf;
    logic signed [SCALE_W-1:0] in_scale;
    logic [FRAC_W-1:0]         in_fraction;
    logic                      in_last;

    logic                      out_valid;
    logic                      out_ready;
    logic signed [ACC_W-1:0]   out_sum;
    logic [CNT_W-1:0]          out_count;
    logic                      out_nar;
    logic                      out_overflow;

    modport slave (
        input  in_valid, in_sign, in_zero, in_inf, in_scale, in_fraction, in_last, out_ready,
        output in_ready, out_valid, out_sum, out_count, out_nar, out_overflow
    );

    modport master (
        output in_valid, in_sign, in_zero, in_inf, in_scale, in_fraction, in_last, out_ready,
        input  in_ready, out_valid, out_sum, out_count, out_nar, out_overflow
    );
endinterface

// File: rtl/posit_accum_stream.sv
// Aligns decoded posit elements into a wide fixed-point accumulator and emits
// one sum/count/flags result per in_last-delimited burst.
module posit_accum_stream #(
    parameter int FRAC_W   = 28,
    parameter int SCALE_W  = 8,
    parameter int ACC_W    = 128,
    parameter int ACC_FRAC = 64,
    parameter int CNT_W    = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    posit_accum_stream_if.slave  bus
);
    typedef enum logic [1:0] {ACCUM, DRAIN, OUTPUT} state_e;

    state_e             state_q, state_d;
    logic               in_ready_q, in_ready_d;
    logic               s1_valid_q, s1_valid_d;
    logic               s1_last_q, s1_last_d;
    logic               s1_nar_q, s1_nar_d;
    logic               s1_ovf_q, s1_ovf_d;
    logic [ACC_W-1:0]   s1_term_q, s1_term_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               nar_q, nar_d;
    logic               ovf_q, ovf_d;
    logic               out_valid_q, out_valid_d;
    logic [ACC_W-1:0]   out_sum_q, out_sum_d;
    logic [CNT_W-1:0]   out_count_q, out_count_d;
    logic               out_nar_q, out_nar_d;
    logic               out_ovf_q, out_ovf_d;

    logic               accept;
    int                 sh;
    logic [ACC_W-1:0]   mag;
    logic [ACC_W-1:0]   shifted;
    logic [ACC_W-1:0]   sum;
    logic               add_ovf;

    always_comb begin
        // NOTE: every signal gets a default first, so no branch can leave one unassigned and infer a latch.
        state_d     = state_q;
        in_ready_d  = in_ready_q;
        s1_valid_d  = 1'b0;
        s1_last_d   = 1'b0;
        s1_nar_d    = 1'b0;
        s1_ovf_d    = 1'b0;
        s1_term_d   = s1_term_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        nar_d       = nar_q;
        ovf_d       = ovf_q;
        out_valid_d = out_valid_q;
        out_sum_d   = out_sum_q;
        out_count_d = out_count_q;
        out_nar_d   = out_nar_q;
        out_ovf_d   = out_ovf_q;

        accept  = bus.in_valid && in_ready_q;
        sh      = int'($signed(bus.in_scale)) - FRAC_W + ACC_FRAC;
        mag     = ACC_W'({1'b1, bus.in_fraction});
        shifted = (sh >= 0) ? (mag << sh) : (mag >> (-sh));

        // Stage 1: zero outranks NaR, which outranks an out-of-range scale.
        if (accept) begin
            s1_valid_d = 1'b1;
            s1_last_d  = bus.in_last;
            s1_term_d  = bus.in_sign ? (~shifted + 1'b1) : shifted;
            if (bus.in_zero) begin
                s1_term_d = '0;
            end else if (bus.in_inf) begin
                s1_term_d = '0;
                s1_nar_d  = 1'b1;
            end else if (int'($signed(bus.in_scale)) > ACC_W - ACC_FRAC - 2) begin
                s1_term_d = '0;
                s1_ovf_d  = 1'b1;
            end
        end

        // Stage 2: wrap-around add with signed-overflow detection.
        sum     = acc_q + s1_term_q;
        add_ovf = (acc_q[ACC_W-1] == s1_term_q[ACC_W-1]) && (sum[ACC_W-1] != acc_q[ACC_W-1]);
        if (s1_valid_q) begin
            acc_d = sum;
            cnt_d = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
            nar_d = nar_q | s1_nar_q;
            ovf_d = ovf_q | s1_ovf_q | add_ovf;
        end

        case (state_q)
            ACCUM: begin
                if (accept && bus.in_last) begin
                    in_ready_d = 1'b0;
                    state_d    = DRAIN;
                end
            end
            DRAIN: begin
                if (s1_valid_q && s1_last_q) begin
                    out_sum_d   = nar_d ? '0 : sum;
                    out_count_d = cnt_d;
                    out_nar_d   = nar_d;
                    out_ovf_d   = ovf_d;
                    out_valid_d = 1'b1;
                    state_d     = OUTPUT;
                end
            end
            OUTPUT: begin
                if (out_valid_q && bus.out_ready) begin
                    out_valid_d = 1'b0;
                    acc_d       = '0;
                    cnt_d       = '0;
                    nar_d       = 1'b0;
                    ovf_d       = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = ACCUM;
                end
            end
            default: state_d = ACCUM;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= ACCUM;
        else       state_q <= state_d;
    end

    // NOTE: non-blocking assignments so every flop updates from values sampled before the edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            in_ready_q  <= 1'b1;
            s1_valid_q  <= 1'b0;
            s1_last_q   <= 1'b0;
            s1_nar_q    <= 1'b0;
            s1_ovf_q    <= 1'b0;
            s1_term_q   <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            nar_q       <= 1'b0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_count_q <= '0;
            out_nar_q   <= 1'b0;
            out_ovf_q   <= 1'b0;
        end else begin
            in_ready_q  <= in_ready_d;
            s1_valid_q  <= s1_valid_d;
            s1_last_q   <= s1_last_d;
            s1_nar_q    <= s1_nar_d;
            s1_ovf_q    <= s1_ovf_d;
            s1_term_q   <= s1_term_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            nar_q       <= nar_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
            out_sum_q   <= out_sum_d;
            out_count_q <= out_count_d;
            out_nar_q   <= out_nar_d;
            out_ovf_q   <= out_ovf_d;
        end
    end

    assign bus.in_ready     = in_ready_q;
    assign bus.out_valid    = out_valid_q;
    assign bus.out_sum      = out_sum_q;
    assign bus.out_count    = out_count_q;
    assign bus.out_nar      = out_nar_q;
    assign bus.out_overflow = out_ovf_q;
endmodule

// File: tb/tb_posit_accum_stream.sv
// Directed bench for posit_accum_stream: expected burst results are queued as
// stimulus is driven and compared when each result appears.
module tb_posit_accum_stream;
    localparam int FRAC_W   = 28;
    localparam int SCALE_W  = 8;
    localparam int ACC_W    = 128;
    localparam int ACC_FRAC = 64;
    localparam int CNT_W    = 16;

    localparam logic [ACC_W-1:0]  ONE      = 128'h1 << ACC_FRAC;
    localparam logic [FRAC_W-1:0] FRAC_0   = '0;
    localparam logic [FRAC_W-1:0] FRAC_HALF = 28'h800_0000;

    typedef struct {
        logic [ACC_W-1:0] sum;
        logic [CNT_W-1:0] cnt;
        logic             nar;
        logic             ovf;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    posit_accum_stream_if #(.FRAC_W(FRAC_W), .SCALE_W(SCALE_W), .ACC_W(ACC_W), .CNT_W(CNT_W)) bus ();

    posit_accum_stream #(
        .FRAC_W(FRAC_W), .SCALE_W(SCALE_W), .ACC_W(ACC_W), .ACC_FRAC(ACC_FRAC), .CNT_W(CNT_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [ACC_W-1:0] obs, input logic [ACC_W-1:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_burst(input logic [ACC_W-1:0] sum, input int cnt, input logic nar, input logic ovf);
        exp_t e;
        e.sum = sum;
        e.cnt = cnt[CNT_W-1:0];
        e.nar = nar;
        e.ovf = ovf;
        exp_q.push_back(e);
    endtask

    task automatic send(input logic sg, input logic zr, input logic nf, input int scale,
                        input logic [FRAC_W-1:0] frac, input logic last);
        logic rdy;
        logic took;
        took            = 1'b0;
        bus.in_sign     = sg;
        bus.in_zero     = zr;
        bus.in_inf      = nf;
        bus.in_scale    = scale[SCALE_W-1:0];
        bus.in_fraction = frac;
        bus.in_last     = last;
        bus.in_valid    = 1'b1;
        for (int i = 0; i < 20 && !took; i++) begin
            rdy = bus.in_ready;
            tick();
            took = rdy;
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        check("accept", took, 1);
    endtask

    // Called right after the last element's accept edge.
    task automatic collect(input string tag);
        exp_t e;
        logic seen;
        check({tag, "_drain_ready"}, bus.in_ready, 0);
        check({tag, "_early"}, bus.out_valid, 0);
        tick();
        check({tag, "_latency"}, bus.out_valid, 1);
        seen = bus.out_valid;
        for (int i = 0; i < 10 && !seen; i++) begin
            tick();
            seen = bus.out_valid;
        end
        check({tag, "_queue"}, 128'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check({tag, "_sum"}, bus.out_sum, e.sum);
            check({tag, "_count"}, 128'(bus.out_count), 128'(e.cnt));
            check({tag, "_nar"}, bus.out_nar, e.nar);
            check({tag, "_ovf"}, bus.out_overflow, e.ovf);
        end
    endtask

    task automatic handshake(input string tag);
        bus.out_ready = 1'b1;
        tick();
        check({tag, "_done_valid"}, bus.out_valid, 0);
        check({tag, "_done_ready"}, bus.in_ready, 1);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_in_ready"}, bus.in_ready, 1);
        check({tag, "_out_valid"}, bus.out_valid, 0);
        check({tag, "_out_sum"}, bus.out_sum, 0);
        check({tag, "_out_count"}, 128'(bus.out_count), 0);
        check({tag, "_out_nar"}, bus.out_nar, 0);
        check({tag, "_out_ovf"}, bus.out_overflow, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not reach the summary");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset           = 1'b1;
        bus.in_valid    = 1'b0;
        bus.in_sign     = 1'b0;
        bus.in_zero     = 1'b0;
        bus.in_inf      = 1'b0;
        bus.in_scale    = '0;
        bus.in_fraction = '0;
        bus.in_last     = 1'b0;
        bus.out_ready   = 1'b1;
        #3;
        check_idle("reset");
        #4;
        reset = 1'b0;
        tick();

        // Three times 1.0.
        expect_burst(3 * ONE, 3, 1'b0, 1'b0);
        send(0, 0, 0, 0, FRAC_0, 0);
        send(0, 0, 0, 0, FRAC_0, 0);
        send(0, 0, 0, 0, FRAC_0, 1);
        collect("three_ones");
        handshake("three_ones");

        // +1.5 then -0.25.
        expect_burst(ONE + ONE / 2 - ONE / 4, 2, 1'b0, 1'b0);
        send(0, 0, 0, 0, FRAC_HALF, 0);
        send(1, 0, 0, -2, FRAC_0, 1);
        collect("mixed_sign");
        handshake("mixed_sign");

        // NaR in the middle forces a zero sum.
        expect_burst('0, 3, 1'b1, 1'b0);
        send(0, 0, 0, 0, FRAC_0, 0);
        send(0, 0, 1, 0, FRAC_0, 0);
        send(0, 0, 0, 1, FRAC_0, 1);
        collect("nar");
        handshake("nar");

        // Scale beyond the accumulator range contributes nothing but flags overflow.
        expect_burst(ONE, 2, 1'b0, 1'b1);
        send(0, 0, 0, 0, FRAC_0, 0);
        send(0, 0, 0, 100, FRAC_0, 1);
        collect("scale_ovf");
        handshake("scale_ovf");

        // Tiny value truncates to zero; single-element burst.
        expect_burst('0, 1, 1'b0, 1'b0);
        send(0, 0, 0, -70, FRAC_0, 1);
        collect("truncate");
        handshake("truncate");

        // Smallest representable value lands on the LSB.
        expect_burst(128'h1, 1, 1'b0, 1'b0);
        send(0, 0, 0, -64, FRAC_0, 1);
        collect("lsb");
        handshake("lsb");

        // Largest in-range scale.
        expect_burst(128'h1 << 126, 1, 1'b0, 1'b0);
        send(0, 0, 0, 62, FRAC_0, 1);
        collect("max_scale");
        handshake("max_scale");

        // First out-of-range scale.
        expect_burst('0, 1, 1'b0, 1'b1);
        send(0, 0, 0, 63, FRAC_0, 1);
        collect("over_scale");
        handshake("over_scale");

        // Two maximal terms wrap into the sign bit.
        expect_burst(128'h1 << 127, 2, 1'b0, 1'b1);
        send(0, 0, 0, 62, FRAC_0, 0);
        send(0, 0, 0, 62, FRAC_0, 1);
        collect("sum_ovf");
        handshake("sum_ovf");

        // Negative result.
        expect_burst(-ONE, 1, 1'b0, 1'b0);
        send(1, 0, 0, 0, FRAC_0, 1);
        collect("neg_one");
        handshake("neg_one");

        // Zero flag outranks NaR flag.
        expect_burst(ONE, 2, 1'b0, 1'b0);
        send(0, 1, 1, 0, FRAC_0, 0);
        send(0, 0, 0, 0, FRAC_0, 1);
        collect("zero_prio");
        handshake("zero_prio");

        // Back-pressure: result held, offered input ignored.
        bus.out_ready = 1'b0;
        expect_burst(3 * ONE, 2, 1'b0, 1'b0);
        send(0, 0, 0, 1, FRAC_0, 0);
        send(0, 0, 0, 0, FRAC_0, 1);
        collect("stall");
        bus.in_scale    = 8'sd2;
        bus.in_fraction = FRAC_0;
        bus.in_sign     = 1'b0;
        bus.in_last     = 1'b1;
        bus.in_valid    = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stall_valid", bus.out_valid, 1);
            check("stall_sum", bus.out_sum, 3 * ONE);
            check("stall_count", 128'(bus.out_count), 2);
            check("stall_in_ready", bus.in_ready, 0);
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        handshake("stall");
        expect_burst(ONE, 1, 1'b0, 1'b0);
        send(0, 0, 0, 0, FRAC_0, 1);
        collect("after_stall");
        handshake("after_stall");

        // Reset mid-burst discards the partial sum.
        send(0, 0, 0, 0, FRAC_0, 0);
        send(0, 0, 0, 0, FRAC_0, 0);
        reset = 1'b1;
        #1;
        check_idle("mid_reset");
        #2;
        reset = 1'b0;
        expect_burst(2 * ONE, 1, 1'b0, 1'b0);
        send(0, 0, 0, 1, FRAC_0, 1);
        collect("post_reset");
        handshake("post_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
